// File: rtl/frame_strobe_sequencer.sv
// frame_strobe_sequencer: drives FrameData, then pulses one FrameStrobe bit per accepted frame-write request
// Ports: UserCLK/reset (sync, active-high); req_valid/req_ready handshake with req_col/req_frame/req_data;
//        FrameData shared data word; FrameStrobe one-hot, bit col*MaxFramesPerCol+frame;
//        busy while a transaction runs; addr_err one-cycle pulse for a rejected out-of-range request
module frame_strobe_sequencer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumColumns      = 10,
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 1,
    parameter int HOLD_CYCLES     = 1
) (
    input  logic                                  UserCLK,
    input  logic                                  reset,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [$clog2(NumColumns)-1:0]         req_col,
    input  logic [$clog2(MaxFramesPerCol)-1:0]    req_frame,
    input  logic [FrameBitsPerRow-1:0]            req_data,
    output logic [FrameBitsPerRow-1:0]            FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  addr_err
);
    localparam int CLW  = $clog2(NumColumns);
    localparam int FW   = $clog2(MaxFramesPerCol);
    localparam int SW   = NumColumns * MaxFramesPerCol;
    localparam int IW   = $clog2(SW);
    localparam int MAXP = (SETUP_CYCLES > STROBE_CYCLES)
                          ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                          : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
    localparam int CW   = $clog2(MAXP + 1);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d, lim;
    logic [CLW-1:0]       col_q, col_d;
    logic [FW-1:0]        frame_q, frame_d;
    logic [FrameBitsPerRow-1:0] data_d;
    logic [SW-1:0]        strobe_d;
    logic [IW-1:0]        idx;
    logic                 addr_err_d, in_range, done;
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    always_comb begin
        in_range   = int'(req_col) < NumColumns && int'(req_frame) < MaxFramesPerCol;
        lim        = state == SETUP  ? CW'(SETUP_CYCLES - 1)
                   : state == STROBE ? CW'(STROBE_CYCLES - 1) : CW'(HOLD_CYCLES - 1);
        done       = cnt == lim;
        idx        = IW'(int'(col_q) * MaxFramesPerCol + int'(frame_q));
        state_d    = state;
        col_d      = col_q;
        frame_d    = frame_q;
        data_d     = FrameData;
        addr_err_d = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                if (in_range) begin
                    state_d = SETUP;
                    col_d   = req_col;
                    frame_d = req_frame;
                    data_d  = req_data;
                end else addr_err_d = 1'b1;
            end
            SETUP:   if (done) state_d = STROBE;
            STROBE:  if (done) state_d = HOLD;
            default: if (done) state_d = IDLE;
        endcase
        // counter restarts on every state entry; the strobe is decoded from the next state so it is registered
        cnt_d    = (state_d != state || state == IDLE) ? '0 : cnt + 1'b1;
        strobe_d = state_d == STROBE ? SW'(1) << idx : '0;
    end
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            col_q       <= '0;
            frame_q     <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            addr_err    <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            col_q       <= col_d;
            frame_q     <= frame_d;
            FrameData   <= data_d;
            FrameStrobe <= strobe_d;
            addr_err    <= addr_err_d;
        end
    end
endmodule
